// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
   localparam int NUM_REQ_DEF = 2;
   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;
   localparam logic [DW_DEF/8-1:0] BE_FULL = '1;
   localparam logic [DW_DEF/8-1:0] BE_NONE = '0;
   typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;
endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: per-byte select between old and new word under a byte mask
module dmem_byte_merge #(
   parameter int DW = 32
) (
   input  logic [DW-1:0]   old_i,
   input  logic [DW-1:0]   new_i,
   input  logic [DW/8-1:0] be_i,
   output logic [DW-1:0]   merged_o
);
   for (genvar b = 0; b < DW/8; b++) begin : g_byte
      assign merged_o[8*b +: 8] = be_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data memory between two requesters
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ-1:0][DW/8-1:0]  req_be,
   input  logic [NUM_REQ-1:0][AW-1:0]    req_addr,
   input  logic [NUM_REQ-1:0][DW-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DW-1:0]                 resp_rdata,
   output logic                          mem_we,
   output logic                          mem_re,
   output logic [AW-1:0]                 mem_addr,
   output logic [DW-1:0]                 mem_wdata,
   input  logic [DW-1:0]                 mem_rdata,
   output logic                          busy
);
   state_t          state_q, state_d;
   logic            gnt, gnt_q, last_q, accept;
   logic [DW/8-1:0] be_q;
   logic [AW-1:0]   addr_q, maddr_q;
   logic [DW-1:0]   wdata_q, old_q, rdata_q, mwdata_q, merged;

   dmem_byte_merge #(.DW(DW)) u_merge (
      .old_i    (old_q),
      .new_i    (wdata_q),
      .be_i     (be_q),
      .merged_o (merged)
   );

   // pick the requester: the sole valid one, or the one not granted last time
   always_comb begin
      gnt = (req_valid[0] & req_valid[1]) ? ~last_q : req_valid[1];
      accept = (state_q == IDLE) & (|req_valid) & ~rst;
   end

   // next state and all outputs; mem address/data hold their last driven value when idle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:           if (accept) state_d = !req_we[gnt] ? RD :
                                               (req_be[gnt] == BE_FULL) ? WR :
                                               (req_be[gnt] == BE_NONE) ? RESP : RMW_RD;
         RMW_RD:         state_d = RMW_WR;
         RD, RMW_WR, WR: state_d = RESP;
         default:        state_d = IDLE;
      endcase
      req_ready = accept ? NUM_REQ'(1) << gnt : '0;
      resp_valid = (state_q == RESP) ? NUM_REQ'(1) << gnt_q : '0;
      mem_re = (state_q == RD) | (state_q == RMW_RD);
      mem_we = (state_q == WR) | (state_q == RMW_WR);
      mem_addr = (mem_re | mem_we) ? addr_q : maddr_q;
      mem_wdata = (state_q == WR) ? wdata_q : (state_q == RMW_WR) ? merged : mwdata_q;
      resp_rdata = rdata_q;
      busy = state_q != IDLE;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end

   // request latch, read captures and held memory-bus values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q <= 1'b0;
         last_q <= 1'b1;
         be_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         old_q <= '0;
         rdata_q <= '0;
         maddr_q <= '0;
         mwdata_q <= '0;
      end else begin
         if (accept) begin
            gnt_q <= gnt;
            last_q <= gnt;
            be_q <= req_be[gnt];
            addr_q <= req_addr[gnt] & ~AW'(3);
            wdata_q <= req_wdata[gnt];
         end
         if (state_q == RD) rdata_q <= mem_rdata;
         if (state_q == RMW_RD) old_q <= mem_rdata;
         if (mem_re | mem_we) maddr_q <= addr_q;
         if (mem_we) mwdata_q <= mem_wdata;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a word-memory model
module tb_dmem_arbiter;
   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid, req_ready, req_we, resp_valid;
   logic [1:0][3:0]  req_be;
   logic [1:0][31:0] req_addr, req_wdata;
   logic [31:0]      resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic             mem_we, mem_re, busy;
   logic [31:0]      dmem [0:63];
   logic [31:0]      refm [0:63];
   int               errors = 0;
   int               checks = 0;
   int               overlap = 0;

   typedef struct {
      int          lat;
      int          nwe;
      int          nre;
      int          wek;
      int          rek;
      logic [31:0] rd;
      logic [31:0] wd;
      logic        wrong;
   } obs_t;

   dmem_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // DMem: synchronous write, combinational read
   always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
   assign mem_rdata = mem_re ? dmem[mem_addr[7:2]] : 32'h0;

   // count any cycle with both strobes high
   always @(negedge clk) if (mem_we && mem_re) overlap++;

   function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] mask;
      mask = 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
      return (nw & mask) | (old & ~mask);
   endfunction

   task automatic txn(input int r, input logic w, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] d, output obs_t o);
      int n;
      o = '{lat:-1, nwe:0, nre:0, wek:-1, rek:-1, rd:32'h0, wd:32'h0, wrong:1'b0};
      @(negedge clk);
      req_we[r] = w; req_be[r] = be; req_addr[r] = a; req_wdata[r] = d; req_valid[r] = 1'b1;
      n = 0;
      #1;
      while (!req_ready[r] && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL txn_accept: req%0d ready seen=0 required=1", r);
         req_valid[r] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (mem_we) begin o.nwe++; o.wek = k; o.wd = mem_wdata; end
         if (mem_re) begin o.nre++; o.rek = k; end
         if (resp_valid[r] && o.lat < 0) begin o.lat = k; o.rd = resp_rdata; end
         if (resp_valid[1-r]) o.wrong = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 2'b00; req_we = 2'b00; req_be = '0; req_addr = '0; req_wdata = '0;
      #1 rst = 1'b1;
      req_valid = 2'b11;
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got=%b want=00", req_ready); end
      checks++;
      if ({resp_valid, mem_we, mem_re, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: resp_valid=%b we=%b re=%b busy=%b want all 0", resp_valid, mem_we, mem_re, busy);
      end
      checks++;
      if ({mem_addr, mem_wdata, resp_rdata} !== 96'h0) begin
         errors++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, resp_rdata);
      end
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_write_read();
      obs_t o;
      txn(0, 1'b1, 4'hF, 32'd8, 32'hAABBCCDD, o);
      refm[2] = 32'hAABBCCDD;
      checks++;
      if (o.lat !== 2 || o.wrong) begin errors++; $display("FAIL fw_resp: lat=%0d wrong=%b want lat=2", o.lat, o.wrong); end
      checks++;
      if (o.nwe !== 1 || o.wek !== 1 || o.nre !== 0 || o.wd !== 32'hAABBCCDD) begin
         errors++; $display("FAIL fw_mem: nwe=%0d at=%0d nre=%0d wd=%h want 1,1,0,aabbccdd", o.nwe, o.wek, o.nre, o.wd);
      end
      txn(0, 1'b0, 4'h0, 32'd8, 32'h0, o);
      checks++;
      if (o.lat !== 2 || o.rd !== refm[2]) begin errors++; $display("FAIL fr_resp: lat=%0d rd=%h want 2 %h", o.lat, o.rd, refm[2]); end
      checks++;
      if (o.nre !== 1 || o.rek !== 1 || o.nwe !== 0) begin
         errors++; $display("FAIL fr_mem: nre=%0d at=%0d nwe=%0d want 1,1,0", o.nre, o.rek, o.nwe);
      end
   endtask

   task automatic test_partial_write();
      obs_t o;
      txn(0, 1'b1, 4'hF, 32'd12, 32'h12345678, o);
      refm[3] = 32'h12345678;
      txn(1, 1'b1, 4'b0011, 32'd12, 32'hFFFFEEEE, o);
      refm[3] = merge_ref(refm[3], 32'hFFFFEEEE, 4'b0011);
      checks++;
      if (o.lat !== 3 || o.wrong) begin errors++; $display("FAIL pw_resp: lat=%0d wrong=%b want 3", o.lat, o.wrong); end
      checks++;
      if (o.nre !== 1 || o.rek !== 1 || o.nwe !== 1 || o.wek !== 2) begin
         errors++; $display("FAIL pw_seq: re=%0d@%0d we=%0d@%0d want 1@1 1@2", o.nre, o.rek, o.nwe, o.wek);
      end
      checks++;
      if (o.wd !== 32'h1234EEEE) begin errors++; $display("FAIL pw_wdata: got=%h want=1234eeee", o.wd); end
      txn(1, 1'b0, 4'h0, 32'd12, 32'h0, o);
      checks++;
      if (o.rd !== 32'h1234EEEE || o.lat !== 2) begin errors++; $display("FAIL pw_readback: rd=%h lat=%0d want 1234eeee 2", o.rd, o.lat); end
   endtask

   task automatic test_arbitration();
      int grants[$];
      int resps[$];
      logic [31:0] rdat[$];
      logic [1:0] drop;
      int n;
      int exp_g [4] = '{0, 1, 0, 1};
      logic [31:0] exp_d [4];
      int bad;
      exp_d = '{refm[2], refm[3], refm[2], refm[3]};
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int p = 0; p < 2; p++) begin
         req_we = 2'b00; req_addr[0] = 32'd8; req_addr[1] = 32'd13; req_valid = 2'b11;
         while ((req_valid != 2'b00 || busy) && n < 40) begin
            #1;
            drop = req_ready;
            if (req_ready[0]) grants.push_back(0);
            if (req_ready[1]) grants.push_back(1);
            for (int i = 0; i < 2; i++) if (resp_valid[i]) begin resps.push_back(i); rdat.push_back(resp_rdata); end
            @(posedge clk); #1;
            req_valid = req_valid & ~drop;
            @(negedge clk);
            n++;
         end
      end
      req_valid = 2'b00;
      checks++;
      if (n >= 40) begin errors++; $display("FAIL arb_timeout: cycles=%0d limit=40", n); end
      checks++;
      if (grants.size() !== 4 || resps.size() !== 4) begin
         errors++; $display("FAIL arb_count: grants=%0d resps=%0d want 4 4", grants.size(), resps.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 4; i++) if (grants[i] != exp_g[i] || resps[i] != exp_g[i] || rdat[i] !== exp_d[i]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL arb_order: grants=%0d%0d%0d%0d resps=%0d%0d%0d%0d want 0101/0101, data %h %h", grants[0], grants[1],
                     grants[2], grants[3], resps[0], resps[1], resps[2], resps[3], rdat[0], rdat[1]);
         end
      end
   endtask

   task automatic test_empty_mask();
      obs_t o;
      txn(0, 1'b1, 4'h0, 32'd16, 32'hDEADBEEF, o);
      checks++;
      if (o.lat !== 1 || o.wrong) begin errors++; $display("FAIL em_resp: lat=%0d wrong=%b want 1", o.lat, o.wrong); end
      checks++;
      if (o.nwe !== 0 || o.nre !== 0) begin errors++; $display("FAIL em_mem: nwe=%0d nre=%0d want 0 0", o.nwe, o.nre); end
      checks++;
      if (dmem[4] !== refm[4]) begin errors++; $display("FAIL em_data: mem=%h want=%h", dmem[4], refm[4]); end
   endtask

   task automatic test_reset_mid_rmw();
      logic seen_we, seen_resp, seen_ready;
      @(negedge clk);
      req_we[0] = 1'b1; req_be[0] = 4'b1000; req_addr[0] = 32'd12; req_wdata[0] = $urandom; req_valid[0] = 1'b1;
      #1;
      checks++;
      if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rr_accept: ready=%b want 1", req_ready[0]); end
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (mem_re !== 1'b1) begin errors++; $display("FAIL rr_rmwrd: mem_re=%b want 1", mem_re); end
      rst = 1'b1;
      req_valid = 2'b11;
      #1;
      checks++;
      if ({mem_we, mem_re, busy, req_ready, resp_valid} !== 7'b0) begin
         errors++; $display("FAIL rr_async: we=%b re=%b busy=%b ready=%b resp=%b want 0", mem_we, mem_re, busy, req_ready, resp_valid);
      end
      seen_we = 1'b0; seen_resp = 1'b0; seen_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         seen_we |= mem_we; seen_resp |= |resp_valid; seen_ready |= |req_ready;
      end
      req_valid = 2'b00;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         seen_we |= mem_we; seen_resp |= |resp_valid;
      end
      checks++;
      if (seen_we || seen_resp || seen_ready) begin
         errors++; $display("FAIL rr_quiet: we=%b resp=%b ready=%b want 0", seen_we, seen_resp, seen_ready);
      end
      checks++;
      if (dmem[3] !== refm[3]) begin errors++; $display("FAIL rr_mem: mem=%h want=%h", dmem[3], refm[3]); end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int bad;
      int ov0;
      ov0 = overlap;
      @(negedge clk);
      req_we[0] = 1'b0; req_addr[0] = 32'd8; req_valid[0] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req_ready[0]) acc.push_back(c);
         if (c < 11) @(negedge clk);
      end
      req_valid[0] = 1'b0;
      repeat (5) @(negedge clk);
      bad = 0;
      for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 3) bad++;
      checks++;
      if (acc.size() != 4 || bad != 0) begin
         errors++; $display("FAIL b2b_period: accepts=%0d bad_gaps=%0d want 4 0", acc.size(), bad);
      end
      checks++;
      if (overlap != ov0) begin errors++; $display("FAIL b2b_overlap: cycles=%0d want 0", overlap - ov0); end
   endtask

   task automatic test_random();
      obs_t o;
      int r, sel, idx, exp_lat, exp_we, exp_re, bad;
      logic w;
      logic [3:0] be;
      logic [31:0] a, d, exp_v;
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 1);
         w = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 3);
         be = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(1, 14));
         idx = $urandom_range(0, 63);
         a = (idx << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         exp_v = refm[idx];
         if (!w) begin exp_lat = 2; exp_re = 1; exp_we = 0; end
         else if (be == 4'hF) begin exp_lat = 2; exp_re = 0; exp_we = 1; exp_v = d; end
         else if (be == 4'h0) begin exp_lat = 1; exp_re = 0; exp_we = 0; end
         else begin exp_lat = 3; exp_re = 1; exp_we = 1; exp_v = merge_ref(refm[idx], d, be); end
         txn(r, w, be, a, d, o);
         if (w) refm[idx] = exp_v;
         checks++;
         if (o.lat !== exp_lat || o.wrong) begin
            errors++; $display("FAIL rnd_lat t=%0d: lat=%0d wrong=%b want %0d", t, o.lat, o.wrong, exp_lat);
         end
         checks++;
         if (o.nwe !== exp_we || o.nre !== exp_re) begin
            errors++; $display("FAIL rnd_strobes t=%0d: we=%0d re=%0d want %0d %0d", t, o.nwe, o.nre, exp_we, exp_re);
         end
         if (!w) begin
            checks++;
            if (o.rd !== exp_v) begin errors++; $display("FAIL rnd_rdata t=%0d: got=%h want=%h", t, o.rd, exp_v); end
         end else if (exp_we == 1) begin
            checks++;
            if (o.wd !== exp_v) begin errors++; $display("FAIL rnd_wdata t=%0d: got=%h want=%h", t, o.wd, exp_v); end
         end
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (dmem[i] !== refm[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rnd_memory: words_differ=%0d want 0", bad); end
      checks++;
      if (overlap != 0) begin errors++; $display("FAIL rnd_overlap: cycles=%0d want 0", overlap); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         dmem[i] = $urandom;
         refm[i] = dmem[i];
      end
      test_reset();
      test_full_write_read();
      test_partial_write();
      test_arbitration();
      test_empty_mask();
      test_reset_mid_rmw();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single word-wide data memory (DMem: `we`, `re`, `data_addr`, `data_write`, `data_read`) between two requesters, e.g. the CPU load/store unit and a debug/DMA port.
- Arbitrates round-robin with a valid/ready request handshake and a pulsed response.
- Sequences each memory access, including byte-masked stores, which it performs as read-modify-write.
- Sits between the requesters and DMem; one transaction in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (design and verification fixed at 2).
- AW, 32, address width.
- DW, 32, data width (word); byte-enable width is DW/8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  [NUM_REQ]  request pending.
- req_ready  out  [NUM_REQ]  request accepted this cycle.
- req_we  in  [NUM_REQ]  1=write, 0=read.
- req_be  in  [NUM_REQ][DW/8]  byte enables; bit0 selects bits 7:0.
- req_addr  in  [NUM_REQ][AW]  byte address.
- req_wdata  in  [NUM_REQ][DW]  write data.
- resp_valid  out  [NUM_REQ]  one-cycle completion pulse.
- resp_rdata  out  DW  read data, valid with resp_valid.
- mem_we  out  1  to DMem `we`.
- mem_re  out  1  to DMem `re`.
- mem_addr  out  AW  to DMem `data_addr`.
- mem_wdata  out  DW  to DMem `data_write`.
- mem_rdata  in  DW  from DMem `data_read`.
- busy  out  1  state != IDLE.

Behaviour:
- DMem contract:
  - Write occurs at a rising clk edge while mem_we=1.
  - mem_rdata is combinational from mem_addr while mem_re=1.
- Reset (async, rst=1): state=IDLE; last_grant=1; all req_ready=0, resp_valid=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, resp_rdata=0, busy=0.
- req_ready is forced to 0 while rst=1.
- FSM states: IDLE, RD, RMW_RD, RMW_WR, WR, RESP.
- IDLE:
  - Grant selection: if exactly one req_valid is high, grant it. If both are high, grant the requester != last_grant.
  - req_ready[g]=1 combinationally in the same cycle; at the edge, latch we, be, {addr[AW-1:2],2'b00}, wdata and g; set last_grant=g.
  - Next state:
    - read → RD
    - write with be=all-ones → WR
    - write with be=0 → RESP (no memory access)
    - other writes → RMW_RD
- RD: mem_re=1, mem_addr=latched; capture mem_rdata into resp_rdata at the edge → RESP.
- RMW_RD: mem_re=1; capture mem_rdata into an old-word register → RMW_WR.
- RMW_WR: mem_we=1; mem_wdata = per-byte merge (be bit set → new byte, else old byte) → RESP.
- WR: mem_we=1, mem_wdata=latched wdata → RESP.
- RESP: resp_valid[g]=1 for exactly one cycle → IDLE.
  - resp_rdata holds the captured value until the next read capture; it is undefined-free (last value) for writes.
- Latency (accept cycle T):
  - read: resp at T+2
  - full write: resp at T+2
  - partial write: resp at T+3
  - be=0 write: resp at T+1
- req_ready is low in all non-IDLE states; maximum throughput is one transaction per 2–4 cycles.
- No response backpressure: the requester must consume resp_valid when it pulses.
- Requester holds request fields stable while valid && !ready.
- A request dropped before acceptance is never issued.
- addr[1:0] is ignored.
- mem_we and mem_re are never both 1; each is high at most one cycle per transaction.
- mem_* outputs are driven only in their active states; in other states mem_addr/mem_wdata keep their last value and mem_we/mem_re=0.
- Reset mid-transaction: FSM returns to IDLE immediately; mem_we/mem_re deassert asynchronously; no resp_valid is issued; a partial store interrupted before the RMW_WR edge leaves memory unchanged.

Decomposition:
- Package dmem_arb_pkg:
  - state_t enum
  - NUM_REQ, DW, AW defaults
  - BE_FULL, BE_NONE constants
- Sub-module dmem_byte_merge: combinational (old, new, be) → merged word.
- Arbitration and FSM stay in dmem_arbiter.

Test Plan:
- Full write then read: req0 writes 0xAABBCCDD to addr 8 with be=4'hF, then reads addr 8 → mem_we high one cycle (T+1), resp_valid[0] at T+2; read resp_rdata=0xAABBCCDD at T+2; mem_re high only at T+1.
- Partial write: mem[12]=0x12345678; req1 writes 0xFFFFEEEE with be=4'b0011 → mem_re at T+1, mem_we at T+2 with mem_wdata=0x1234EEEE, resp at T+3; readback returns 0x1234EEEE.
- Arbitration: right after reset, req0 and req1 both valid with reads → req0 granted first, req1 granted next in IDLE; a second simultaneous pair is granted req0 then req1 again (alternation); each grant's resp goes to the correct index.
- Empty mask: req0 write with be=4'b0000 → resp_valid[0] at T+1; mem_we and mem_re never assert.
- Reset mid-RMW: assert rst during RMW_RD of a be=4'b1000 write to addr 12 → mem_we never asserts, mem[12] unchanged, no resp_valid, req_ready=0 while rst=1, busy=0.
- Back-to-back: req0 read held valid continuously, req1 idle → req_ready[0] pulses every 3 cycles; no overlap of mem_re and mem_we.
